// File: rtl/blend_pkg.sv
// Shared encodings and helpers for the edge/colour blend stage.
package blend_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_BLEND  = 2'b01;
  localparam logic [1:0] MODE_EDGE   = 2'b10;

  localparam logic [9:0] LUMA_TH = 10'd384;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDone
  } state_e;

  // Pull a channel halfway towards white; the result never exceeds 255.
  function automatic logic [7:0] brighten(input logic [7:0] c);
    return c + ((8'd255 - c) >> 1);
  endfunction

endpackage

// File: rtl/blend_core.sv
// Combinational per-pixel blend arithmetic (bypass, blend, edge-only).
module blend_core
  import blend_pkg::*;
#(
  parameter logic [7:0] EDGE_TH = 8'd255
) (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [7:0] gray,
  input  logic [1:0] mode,
  output logic [7:0] blend_r,
  output logic [7:0] blend_g,
  output logic [7:0] blend_b
);

  logic [9:0] sum;
  logic       is_edge;

  assign sum     = {2'b00, r} + {2'b00, g} + {2'b00, b};
  assign is_edge = (gray == EDGE_TH);

  always_comb begin
    blend_r = r;
    blend_g = g;
    blend_b = b;
    case (mode)
      MODE_BLEND: begin
        if (is_edge) begin
          if (sum < LUMA_TH) begin
            blend_r = r >> 1;
            blend_g = g >> 1;
            blend_b = b >> 1;
          end else begin
            blend_r = brighten(r);
            blend_g = brighten(g);
            blend_b = brighten(b);
          end
        end
      end
      MODE_EDGE: begin
        blend_r = is_edge ? 8'd0 : 8'd255;
        blend_g = is_edge ? 8'd0 : 8'd255;
        blend_b = is_edge ? 8'd0 : 8'd255;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/blend_stream_ctrl.sv
// Frame controller: joins pixel and edge streams, blends them through one
// registered output slot and tags each output with raster position and markers.
module blend_stream_ctrl
  import blend_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [7:0]  EDGE_TH  = 8'd255
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic [1:0] iMode,
  input  logic       iPixValid,
  output logic       oPixReady,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic       iEdgeValid,
  output logic       oEdgeReady,
  input  logic [7:0] iGray,
  output logic       oValid,
  input  logic       iReady,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic       oSOF,
  output logic       oEOL,
  output logic       oEOF,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oBusy,
  output logic       oFrameDone
);

  localparam logic [9:0] XLast = 10'(H_ACTIVE - 1);
  localparam logic [9:0] YLast = 10'(V_ACTIVE - 1);

  state_e     state_q, state_d;
  logic [1:0] mode_q;
  logic [9:0] x_q, y_q;
  logic       frame_end_q;
  logic       valid_q, sof_q, eol_q, eof_q;
  logic [7:0] r_q, g_q, b_q;
  logic [9:0] ox_q, oy_q;

  logic       run, bypass, edge_ok, fire, is_last, out_hs;
  logic [7:0] blend_r, blend_g, blend_b;

  assign run     = (state_q == StRun);
  assign bypass  = (mode_q == MODE_BYPASS);
  assign edge_ok = bypass | iEdgeValid;
  assign is_last = (x_q == XLast) && (y_q == YLast);
  assign out_hs  = valid_q && iReady;
  // frame_end_q blocks a second pass over the raster once the EOF pixel fired.
  assign fire    = run && !frame_end_q && iPixValid && edge_ok && (!valid_q || iReady);

  assign oPixReady  = fire;
  assign oEdgeReady = bypass ? (run && iEdgeValid) : fire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iStart) state_d = StArm;
      StArm:   state_d = StRun;
      StRun:   if (out_hs && eof_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (iAbort) state_d = StIdle;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Reserved mode 11 is folded into bypass at capture time.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_q <= MODE_BYPASS;
    end else if (state_q == StIdle && iStart && !iAbort) begin
      mode_q <= (iMode == MODE_BLEND || iMode == MODE_EDGE) ? iMode : MODE_BYPASS;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_end_q <= 1'b0;
    end else if (iAbort || state_q == StArm) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_end_q <= 1'b0;
    end else if (fire) begin
      frame_end_q <= is_last;
      if (x_q == XLast) begin
        x_q <= '0;
        y_q <= (y_q == YLast) ? '0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  blend_core #(
    .EDGE_TH (EDGE_TH)
  ) u_core (
    .r       (iR),
    .g       (iG),
    .b       (iB),
    .gray    (iGray),
    .mode    (mode_q),
    .blend_r (blend_r),
    .blend_g (blend_g),
    .blend_b (blend_b)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      valid_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else if (iAbort) begin
      valid_q <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
      r_q     <= blend_r;
      g_q     <= blend_g;
      b_q     <= blend_b;
      sof_q   <= (x_q == '0) && (y_q == '0);
      eol_q   <= (x_q == XLast);
      eof_q   <= is_last;
      ox_q    <= x_q;
      oy_q    <= y_q;
    end else if (out_hs) begin
      valid_q <= 1'b0;
    end
  end

  assign oValid     = valid_q;
  assign oR         = r_q;
  assign oG         = g_q;
  assign oB         = b_q;
  assign oSOF       = sof_q;
  assign oEOL       = eol_q;
  assign oEOF       = eof_q;
  assign oX         = ox_q;
  assign oY         = oy_q;
  assign oBusy      = (state_q != StIdle);
  assign oFrameDone = (state_q == StDone);

endmodule

// File: doc/blend_stream_ctrl.md
# blend_stream_ctrl

Frame-level controller that sequences the per-pixel edge/colour blend stage of the real-time style-transfer pipeline. It joins the RGB pixel stream from the colour path with the edge-map (gray) stream from the edge detector and applies the blend arithmetic through one registered output slot. It also generates raster position and frame markers for the downstream VGA/writer stage. It sits between the colour quantiser and the frame writer, and it is armed once per frame by the top-level sequencer.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- EDGE_TH, 8'd255, gray value that marks an edge pixel
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle pulse; arms one frame when IDLE
- iAbort  in  1  one-cycle pulse; cancels the frame in progress
- iMode  in  2  00 bypass, 01 blend, 10 edge-only, 11 reserved (treated as bypass); sampled on iStart
- iPixValid / oPixReady  in/out  1  pixel stream handshake
- iR, iG, iB  in  8 each  input colour
- iEdgeValid / oEdgeReady  in/out  1  edge stream handshake
- iGray  in  8  edge-map value
- oValid / iReady  out/in  1  output handshake
- oR, oG, oB  out  8 each  blended colour
- oSOF, oEOL, oEOF  out  1 each  markers qualified by oValid
- oX, oY  out  10 each  raster position of the current output pixel
- oBusy  out  1  high in ARM, RUN and DONE
- oFrameDone  out  1  one-cycle pulse when the frame completes

## Operation
- FSM states are IDLE, ARM, RUN and DONE.
  - IDLE goes to ARM on iStart.
  - ARM latches iMode and clears the counters. It lasts one cycle, then moves to RUN.
  - RUN moves to DONE when the EOF pixel completes its output handshake (oValid && iReady && oEOF).
  - DONE pulses oFrameDone for one cycle, then returns to IDLE.
- iStart outside IDLE is ignored.
- iAbort in any state returns the FSM to IDLE on the next edge. It clears oValid and the counters. oFrameDone is not pulsed. iAbort wins over a simultaneous iStart.
- Transfer condition: fire = RUN && iPixValid && (edge_ok) && (!oValid || iReady).
  - In blend and edge-only modes, edge_ok = iEdgeValid.
  - In bypass mode, edge_ok = 1.
- oPixReady = fire.
- oEdgeReady = fire in blend and edge-only modes. In bypass mode, oEdgeReady = RUN && iEdgeValid, so the edge stream is drained and discarded.
- Neither stream is consumed unless both are present (join). Both readies are 0 outside RUN.
- Blend arithmetic is per channel c, with sum = iR+iG+iB held as 10-bit unsigned:
  - Blend mode, iGray == EDGE_TH and sum < 384: out = c>>1.
  - Blend mode, iGray == EDGE_TH and sum ≥ 384: out = c + ((8'd255-c)>>1). This never exceeds 255.
  - Blend mode, iGray != EDGE_TH: out = c.
  - Edge-only mode: all channels = (iGray == EDGE_TH) ? 0 : 255.
  - Bypass mode: out = c.
- Counters x and y advance on fire only.
  - x wraps from H_ACTIVE-1 to 0 and increments y.
  - After fire at (H_ACTIVE-1, V_ACTIVE-1), no further fire occurs in that frame.
- Markers are registered with the data:
  - oSOF marks (0,0).
  - oEOL marks x == H_ACTIVE-1.
  - oEOF marks the last pixel of the frame.
- oX and oY are the position registered with the output data.

## Timing
- Reset values: all outputs 0 and the FSM in IDLE, including oValid, the data outputs, the markers, oX, oY, oBusy, oFrameDone and both readies.
- Latency: exactly one cycle from fire to oValid with the corresponding data.
- Throughput: one pixel per clock when both inputs are valid and iReady stays high.
- Backpressure: while oValid && !iReady, the output data, markers and position hold stable and no fire occurs.
- oValid falls only after a completed handshake with no new fire in the same cycle, or on iAbort.
- Last pixel: the DONE state begins in the cycle after the EOF output handshake, and oFrameDone is high during that cycle.
- Earliest restart: iStart in the cycle after DONE.
- oBusy rises the cycle after iStart and falls the cycle after DONE.
- Asynchronous reset mid-frame behaves as iAbort but takes effect immediately.

## Structure
- The shared package (blend_pkg) holds:
  - the mode encoding constants MODE_BYPASS, MODE_BLEND, MODE_EDGE;
  - the FSM state enum;
  - the luminance threshold constant 10'd384.
- One combinational sub-module, blend_core, implements the per-pixel arithmetic. Its inputs are R, G, B, gray and mode; its outputs are R, G, B.
- The controller holds the FSM, the counters, the join/handshake logic and the output register.

## Test plan
- Reset then idle: assert iRST, drive both inputs valid → all outputs 0, readies 0, no fire until iStart.
- Blend, dark edge pixel: mode 01, R/G/B = 100/50/20, gray 255 → output 50/25/10 one cycle after fire. With gray 128 → output 100/50/20.
- Blend, bright edge pixel: R/G/B = 200/200/100 (sum 500), gray 255 → output 227/227/177. Edge-only mode with gray 255 → output 0/0/0.
- Join and backpressure: pixel valid with edge invalid → no fire. Hold iReady low for 5 cycles → oR/oG/oB and markers stable, readies 0.
- Full frame with H_ACTIVE=4, V_ACTIVE=2 and random valid/ready:
  - oSOF on output 0;
  - oEOL on outputs 3 and 7, and oEOF on output 7;
  - oFrameDone is one pulse;
  - exactly 8 pixels are accepted.
- Abort: iAbort at pixel 3 with oValid high → next cycle IDLE, oValid 0, no oFrameDone. A following iStart restarts at (0,0). In bypass mode, the edge stream is drained without gating the pixel stream.
